// File: rtl/level_tick_gen.sv
// Per-level clock divider: 1-cycle tick enable plus 50% clkhz, level switches only at period boundaries.
// Optional LEVEL_SYNC_EN: double-flop synchronizers on en and level.
module level_tick_gen #(
  parameter int N_LEVELS = 4,
  parameter int W_LEVEL  = 2,
  parameter int W_DIV    = 26,
  parameter logic [N_LEVELS*W_DIV-1:0] DIVS = {26'd6250000, 26'd12500000, 26'd25000000, 26'd50000000}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [W_LEVEL-1:0] level,
  output logic               tick,
  output logic               clkhz,
  output logic [W_LEVEL-1:0] level_act,
  output logic               pending
);
  localparam int NL2 = 1 << W_LEVEL;

  typedef enum logic {STOP, RUN} state_t;

  state_t             state;
  logic [W_DIV-1:0]   cnt;
  logic [W_LEVEL-1:0] req_lvl;
  logic               en_i;
  logic [W_LEVEL-1:0] level_i;
  logic               req_ok;
  logic               apply;
  logic [W_LEVEL-1:0] lvl_nxt;

`ifdef LEVEL_SYNC_EN
  logic [1:0]              en_sync;
  logic [1:0][W_LEVEL-1:0] lvl_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync  <= '0;
      lvl_sync <= '0;
    end else begin
      en_sync  <= {en_sync[0], en};
      lvl_sync <= {lvl_sync[0], level};
    end
  end

  assign en_i    = en_sync[1];
  assign level_i = lvl_sync[1];
`else
  assign en_i    = en;
  assign level_i = level;
`endif

  // Reload value per level; divisors of 0 or 1 collapse to a tick every cycle.
  logic [W_DIV-1:0] dm1_tab [NL2];
  for (genvar i = 0; i < NL2; i++) begin : g_tab
    if (i < N_LEVELS) begin : g_lvl
      localparam logic [W_DIV-1:0] D = DIVS[i*W_DIV +: W_DIV];
      assign dm1_tab[i] = (D <= W_DIV'(1)) ? '0 : D - W_DIV'(1);
    end else begin : g_pad
      assign dm1_tab[i] = '0;
    end
  end

  assign req_ok  = 32'(level_i) < N_LEVELS;
  assign apply   = pending && ((state == STOP) || (en_i && cnt == '0));
  assign lvl_nxt = apply ? req_lvl : level_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STOP;
      cnt       <= '0;
      tick      <= 1'b0;
      clkhz     <= 1'b0;
      level_act <= '0;
      req_lvl   <= '0;
      pending   <= 1'b0;
    end else begin
      if (apply) begin
        level_act <= req_lvl;
        pending   <= 1'b0;
      end
      // Requests compare against the level in force after this edge, so a request
      // arriving on a boundary waits for the next one.
      if (req_ok) begin
        if (level_i != lvl_nxt) begin
          req_lvl <= level_i;
          pending <= 1'b1;
        end else begin
          pending <= 1'b0;
        end
      end
      case (state)
        STOP: begin
          tick <= 1'b0;
          if (en_i) begin
            state <= RUN;
            cnt   <= dm1_tab[lvl_nxt];
          end
        end
        RUN: begin
          if (!en_i) begin
            state <= STOP;
            tick  <= 1'b0;
          end else if (cnt == '0) begin
            tick  <= 1'b1;
            clkhz <= ~clkhz;
            cnt   <= dm1_tab[lvl_nxt];
          end else begin
            tick <= 1'b0;
            cnt  <= cnt - W_DIV'(1);
          end
        end
        default: state <= STOP;
      endcase
    end
  end
endmodule

// File: tb/tb_level_tick_gen.sv
// Directed bench for level_tick_gen with divisors {8,6,4} for levels {2,1,0}.
module tb_level_tick_gen;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] level;
  logic       tick;
  logic       clkhz;
  logic [1:0] level_act;
  logic       pending;

  int n_chk  = 0;
  int n_fail = 0;

  level_tick_gen #(
    .N_LEVELS(3),
    .W_LEVEL (2),
    .W_DIV   (8),
    .DIVS    ({8'd8, 8'd6, 8'd4})
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .level    (level),
    .tick     (tick),
    .clkhz    (clkhz),
    .level_act(level_act),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic et, input logic ec,
                      input logic [1:0] el, input logic ep);
    @(posedge clk);
    #1;
    chk({tag, ".tick"},  32'(tick),      32'(et));
    chk({tag, ".clkhz"}, 32'(clkhz),     32'(ec));
    chk({tag, ".lvl"},   32'(level_act), 32'(el));
    chk({tag, ".pend"},  32'(pending),   32'(ep));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    level = 2'd0;
    #1;
    chk("rst.tick",  32'(tick),      32'd0);
    chk("rst.clkhz", 32'(clkhz),     32'd0);
    chk("rst.lvl",   32'(level_act), 32'd0);
    chk("rst.pend",  32'(pending),   32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b1;
    // E0 = k0; level 0 period 4
    step("A0", 1'b0, 1'b0, 2'd0, 1'b0);
    for (int k = 1; k <= 12; k++)
      step($sformatf("A%0d", k), (k % 4) == 0, ((k / 4) % 2) == 1, 2'd0, 1'b0);
    // request level 2 right after the tick at k12; old period still ends at k16
    level = 2'd2;
    for (int k = 13; k <= 16; k++)
      step($sformatf("B%0d", k), k == 16, k < 16, (k < 16) ? 2'd0 : 2'd2, k < 16);
    for (int k = 17; k <= 32; k++)
      step($sformatf("C%0d", k), ((k - 16) % 8) == 0, (((k - 16) / 8) % 2) == 1, 2'd2, 1'b0);
    level = 2'd1;
    for (int k = 33; k <= 40; k++)
      step($sformatf("D%0d", k), k == 40, k == 40, (k < 40) ? 2'd2 : 2'd1, k < 40);
    for (int k = 41; k <= 64; k++) begin
      if (k == 42) level = 2'd3;
      step($sformatf("E%0d", k), ((k - 40) % 6) == 0, (((k - 40) / 6) % 2) == 0, 2'd1, 1'b0);
    end
    for (int k = 65; k <= 69; k++)
      step($sformatf("F%0d", k), 1'b0, 1'b1, 2'd1, 1'b0);
    // en drops exactly at the boundary edge k70
    en = 1'b0;
    for (int k = 70; k <= 72; k++)
      step($sformatf("G%0d", k), 1'b0, 1'b1, 2'd1, 1'b0);
    en = 1'b1;
    for (int k = 73; k <= 85; k++)
      step($sformatf("H%0d", k), (k == 79) || (k == 85), (k < 79) || (k == 85), 2'd1, 1'b0);
    // async reset while tick is high
    #2 rst_n = 1'b0;
    #1;
    chk("arst.tick",  32'(tick),      32'd0);
    chk("arst.clkhz", 32'(clkhz),     32'd0);
    chk("arst.lvl",   32'(level_act), 32'd0);
    chk("arst.pend",  32'(pending),   32'd0);
    #3 rst_n = 1'b1;
    step("R1", 1'b0, 1'b0, 2'd0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
